// File: rtl/sum_display_pkg.sv
// ---------------------------------------------------------------------------
// sum_display_pkg : shared types, segment patterns and sizing helpers
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sum_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Active-low cathodes {dp,g,f,e,d,c,b,a}; dp bit is always 1 (off).
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_pattern(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  // Decimal digits needed to show the largest value of a 'bits'-wide number.
  function automatic int bcd_digits(input int bits);
    int v;
    int n;
    v = (1 << bits) - 1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (v != 0) begin
        n = n + 1;
        v = v / 10;
      end
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dd_seq.sv
// ---------------------------------------------------------------------------
// bcd_dd_seq : sequential shift-and-add-3 binary to BCD converter, MSB first
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_dd_seq #(
  parameter int NBITS = 9,
  parameter int NDIG  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NBITS-1:0]    bin,
  output logic                busy,
  output logic                valid,
  output logic [4*NDIG-1:0]   bcd
);

  localparam int CW = (NBITS > 2) ? $clog2(NBITS) : 1;
  localparam int TW = 4*NDIG + NBITS;

  logic [4*NDIG-1:0] bcd_q, bcd_d, src_bcd_w;
  logic [NBITS-1:0]  sh_q, sh_d, src_sh_w;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [TW-1:0]     step_w;

  function automatic logic [TW-1:0] dd_step(input logic [4*NDIG-1:0] b,
                                            input logic [NBITS-1:0]  s);
    logic [4*NDIG-1:0] adj;
    logic [TW-1:0]     v;
    adj = b;
    for (int i = 0; i < NDIG; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    v = {adj, s};
    return {v[TW-2:0], 1'b0};
  endfunction

  assign busy  = (cnt_q != '0);
  assign valid = valid_q;
  assign bcd   = bcd_q;

  // The first bit is shifted in on the load edge, so the remaining
  // NBITS-1 iterations finish with valid landing one cycle earlier.
  always_comb begin
    src_bcd_w = start ? '0  : bcd_q;
    src_sh_w  = start ? bin : sh_q;
    step_w    = dd_step(src_bcd_w, src_sh_w);
    bcd_d     = bcd_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    if (start) begin
      {bcd_d, sh_d} = step_w;
      cnt_d         = CW'(NBITS - 1);
    end else if (busy) begin
      {bcd_d, sh_d} = step_w;
      cnt_d         = cnt_q - CW'(1);
      valid_d       = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      bcd_q   <= bcd_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sum_display_scan.sv
// ---------------------------------------------------------------------------
// sum_display_scan : A+B+Cin, sequential BCD conversion, multiplexed 7-seg scan
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sum_display_scan #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              Cin,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic [7:0]        seg_cat,
  output logic [DIGITS-1:0] seg_an
);

  import sum_display_pkg::*;

  localparam int NBITS = WIDTH + 1;
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW    = $clog2(REFRESH_DIV);

  if (WIDTH < 2 || WIDTH > 16) begin : g_chk_width
    $error("sum_display_scan: WIDTH must be 2..16");
  end
  if (bcd_digits(NBITS) > DIGITS) begin : g_chk_digits
    $error("sum_display_scan: DIGITS too small for WIDTH+1 bit sum");
  end
  if (REFRESH_DIV < 2) begin : g_chk_div
    $error("sum_display_scan: REFRESH_DIV must be at least 2");
  end

  logic [NBITS-1:0]    sum_w;
  state_e              state_q, state_d;
  logic                start_w;
  logic                dd_busy, dd_valid;
  logic [4*DIGITS-1:0] dd_bcd;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                done_q, done_d;
  logic [RW-1:0]       ref_q, ref_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          cat_q, cat_d;
  logic [DIGITS:0]     lz_w;
  logic [3:0]          digit_w;
  logic                blank_w;

  assign sum_w = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};

  bcd_dd_seq #(
    .NBITS (NBITS),
    .NDIG  (DIGITS)
  ) u_dd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_w),
    .bin   (sum_w),
    .busy  (dd_busy),
    .valid (dd_valid),
    .bcd   (dd_bcd)
  );

  always_comb begin
    state_d = state_q;
    start_w = 1'b0;
    disp_d  = disp_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          start_w = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        if (dd_valid && !dd_busy) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        disp_d  = dd_bcd;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  // lz_w[i] is set when every digit at position i and above is zero.
  always_comb begin
    lz_w[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_w[i] = lz_w[i+1] && (disp_q[4*i +: 4] == 4'd0);
    end
    digit_w = disp_q[{idx_q, 2'b00} +: 4];
    blank_w = (BLANK_LZ != 0) && (idx_q != '0) && lz_w[idx_q];
    cat_d   = blank_w ? SEG_BLANK : seg_pattern(digit_w);
    an_d    = ~(DIGITS'(1) << idx_q);
    ref_d   = ref_q + RW'(1);
    idx_d   = idx_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  assign seg_cat = cat_q;
  assign seg_an  = an_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      disp_q  <= '0;
      done_q  <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      cat_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      cat_q   <= cat_d;
    end
  end

endmodule

`default_nettype wire
